// File: rtl/lsu_gen_pkg.sv
// rtl/lsu_gen_pkg.sv - shared types and address-region decode for the load/store unit
package lsu_gen_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_PUSH  = 2'd2,
    OP_POP   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_XFER,
    ST_DRAIN,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM,
    REG_NONE
  } region_e;

  function automatic region_e region_of(input logic [31:0] a,
                                        input logic [31:0] rom_size,
                                        input logic [31:0] ram_base,
                                        input logic [31:0] ram_depth);
    region_e r;
    if (a < rom_size) begin
      r = REG_ROM;
    end else if ((a >= ram_base) && (a < ram_base + ram_depth)) begin
      r = REG_RAM;
    end else begin
      r = REG_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/lsu_gen_ram.sv
// rtl/lsu_gen_ram.sv - byte-wide single-port RAM, synchronous read and write
module lsu_ram #(
  parameter int unsigned DEPTH = 4096,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lsu_gen.sv
// rtl/lsu_gen.sv - multi-byte little-endian load/store unit with stack pointer and PUSH/POP
module lsu_gen
  import lsu_gen_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned ROM_SIZE  = 32'h4000,
  parameter int unsigned RAM_BASE  = 32'h8000,
  parameter int unsigned RAM_DEPTH = 4096,
  parameter int unsigned SP_RESET  = 32'h8FFF + 1,
  parameter int unsigned SP_LIMIT  = 32'h8C00,
  localparam int unsigned BUS_W    = 8 * MAX_BYTES,
  localparam int unsigned SIZE_W   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              ready,
  input  logic [1:0]        op,
  input  logic [SIZE_W-1:0] size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BUS_W-1:0]  wdata,
  input  logic              sp_we,
  input  logic [ADDR_W-1:0] sp_d,
  output logic              rsp_valid,
  output logic [BUS_W-1:0]  rdata,
  output logic              err,
  output logic [ADDR_W-1:0] spq,
  output logic [ADDR_W-1:0] rom_a,
  output logic              rom_re,
  input  logic [7:0]        rom_q
);

  localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  region_e             reg_q, reg_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [SIZE_W-1:0]   idx_q, idx_d;
  logic [SIZE_W-1:0]   rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0]   ea_q, ea_d;
  logic [ADDR_W-1:0]   stack_q, stack_d;
  logic [BUS_W-1:0]    wdata_q, wdata_d;
  logic [BUS_W-1:0]    rbuf_q, rbuf_d;
  logic [BUS_W-1:0]    rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_rom_q, rd_rom_d;

  logic [ADDR_W:0]     n_in, n_q, last_ext;
  logic [ADDR_W-1:0]   cur_a;
  region_e             reg_first, reg_last;
  logic                is_wr, chk_err, accept;
  logic                ram_we, rom_re_c;
  logic [7:0]          ram_rdata;
  logic [RAM_AW-1:0]   ram_idx;

  assign ready  = ~rst & (state_q == ST_IDLE) & ~rsp_valid_q;
  assign accept = req & ready;

  assign n_in     = (ADDR_W + 1)'(size) + (ADDR_W + 1)'(1);
  assign n_q      = (ADDR_W + 1)'(size_q) + (ADDR_W + 1)'(1);
  assign last_ext = {1'b0, ea_q} + n_q - (ADDR_W + 1)'(1);
  assign cur_a    = ea_q + ADDR_W'(idx_q);
  assign ram_idx  = RAM_AW'(cur_a - ADDR_W'(RAM_BASE));
  assign is_wr    = (op_q == OP_STORE) || (op_q == OP_PUSH);

  // Regions are contiguous, so a matching first/last region means every byte is mapped there.
  always_comb begin
    reg_first = region_of(32'(ea_q), ROM_SIZE, RAM_BASE, RAM_DEPTH);
    reg_last  = region_of(32'(last_ext[ADDR_W-1:0]), ROM_SIZE, RAM_BASE, RAM_DEPTH);
    chk_err   = last_ext[ADDR_W]
              | (reg_first != reg_last)
              | (reg_first == REG_NONE)
              | (is_wr && (reg_first == REG_ROM))
              | ((op_q == OP_PUSH) && (({1'b0, stack_q} < n_q) || (ea_q < ADDR_W'(SP_LIMIT))))
              | ((op_q == OP_POP) && (({1'b0, stack_q} + n_q) > (ADDR_W + 1)'(SP_RESET)));
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    reg_d       = reg_q;
    size_d      = size_q;
    idx_d       = idx_q;
    rd_idx_d    = rd_idx_q;
    ea_d        = ea_q;
    stack_d     = stack_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rd_pend_d   = 1'b0;
    rd_rom_d    = rd_rom_q;
    ram_we      = 1'b0;
    rom_re_c    = 1'b0;

    // Read data lands one cycle after the byte was issued.
    if (rd_pend_q) begin
      rbuf_d[8*rd_idx_q +: 8] = rd_rom_q ? rom_q : ram_rdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = op_e'(op);
          size_d  = size;
          wdata_d = wdata;
          case (op_e'(op))
            OP_PUSH: ea_d = stack_q - n_in[ADDR_W-1:0];
            OP_POP:  ea_d = stack_q;
            default: ea_d = addr;
          endcase
          state_d = ST_CHECK;
        end else if (ready && sp_we) begin
          stack_d = sp_d;
        end
      end
      ST_CHECK: begin
        rbuf_d  = '0;
        idx_d   = '0;
        reg_d   = reg_first;
        err_d   = chk_err;
        state_d = chk_err ? ST_RESP : ST_XFER;
      end
      ST_XFER: begin
        if (reg_q == REG_ROM) begin
          rom_re_c = ~is_wr;
        end else begin
          ram_we = is_wr;
        end
        if (!is_wr) begin
          rd_pend_d = 1'b1;
          rd_idx_d  = idx_q;
          rd_rom_d  = (reg_q == REG_ROM);
        end
        if (idx_q == size_q) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + SIZE_W'(1);
        end
      end
      ST_DRAIN: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        if (!err_q) begin
          case (op_q)
            OP_PUSH: stack_d = stack_q - n_q[ADDR_W-1:0];
            OP_POP:  stack_d = stack_q + n_q[ADDR_W-1:0];
            default: stack_d = stack_q;
          endcase
          if (!is_wr) begin
            rdata_d = rbuf_q;
          end
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOAD;
      reg_q       <= REG_NONE;
      size_q      <= '0;
      idx_q       <= '0;
      rd_idx_q    <= '0;
      ea_q        <= '0;
      stack_q     <= ADDR_W'(SP_RESET);
      wdata_q     <= '0;
      rbuf_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_rom_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      reg_q       <= reg_d;
      size_q      <= size_d;
      idx_q       <= idx_d;
      rd_idx_q    <= rd_idx_d;
      ea_q        <= ea_d;
      stack_q     <= stack_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_pend_q   <= rd_pend_d;
      rd_rom_q    <= rd_rom_d;
    end
  end

  lsu_ram #(
    .DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (wdata_q[8*idx_q +: 8]),
    .rdata (ram_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign err       = rsp_err_q;
  assign rdata     = rdata_q;
  assign spq       = stack_q;
  assign rom_a     = cur_a;
  assign rom_re    = rom_re_c;

endmodule
